// File: rtl/vertical_bus_collector_if.sv
// Bus/handshake bundle between the last-row PEs, the collector and the
// downstream consumer. master = collector side, slave = environment side.
interface vertical_bus_collector_if #(
  parameter int BITWIDTH = 16,
  parameter int NUM_COLS = 8
);
  logic                start;
  logic [NUM_COLS-1:0] send_enable;
  logic [BITWIDTH-1:0] vertical_bus;
  logic [BITWIDTH-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] row_max;
  logic                row_max_valid;
  logic                busy;
  logic                done;

  modport master (
    input  start, vertical_bus, out_ready,
    output send_enable, out_data, out_valid, row_max, row_max_valid, busy, done
  );

  modport slave (
    output start, vertical_bus, out_ready,
    input  send_enable, out_data, out_valid, row_max, row_max_valid, busy, done
  );
endinterface

// File: rtl/vertical_bus_collector.sv
// Collects one row from the shared vertical bus: grants the last-row PEs in
// column order, buffers each sample in a FIFO and tracks the signed row max.
module vertical_bus_collector #(
  parameter int BITWIDTH   = 16,
  parameter int NUM_COLS   = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  vertical_bus_collector_if.master bus
);
  localparam int COLW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [COLW-1:0] LAST_COL = COLW'(NUM_COLS - 1);
  localparam logic [CW-1:0]   DEPTH    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                     r_state, w_state_next;
  logic [COLW-1:0]            r_col;
  logic [CW-1:0]              r_count;
  logic [AW-1:0]              r_rd_ptr, r_wr_ptr;
  logic [BITWIDTH-1:0]        r_mem [FIFO_DEPTH];
  logic signed [BITWIDTH-1:0] r_run_max, r_row_max, w_new_max, w_bus;
  logic                       w_grant, w_pop, w_last;

  assign w_bus = bus.vertical_bus;

  // Grant/pop qualifiers: grant depends only on registered state and count.
  always_comb begin
    w_grant = (r_state == SCAN) && (r_count < DEPTH);
    w_pop   = (r_count != '0) && bus.out_ready;
    w_last  = (r_col == LAST_COL);
  end

  // Running max candidate: column 0 restarts the row, later columns keep the signed greater.
  always_comb begin
    w_new_max = r_run_max;
    if ((r_col == '0) || (w_bus > r_run_max)) w_new_max = w_bus;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_next = SCAN;
      SCAN:    if (w_grant && w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state, column and FIFO occupancy.
  always_comb begin
    bus.send_enable = '0;
    for (int unsigned i = 0; i < NUM_COLS; i++)
      bus.send_enable[i] = w_grant && (r_col == COLW'(i));
    bus.out_data      = r_mem[r_rd_ptr];
    bus.out_valid     = (r_count != '0);
    bus.row_max       = r_row_max;
    bus.row_max_valid = (r_state == DONE);
    bus.done          = (r_state == DONE);
    bus.busy          = (r_state != IDLE);
  end

  // Column counter and max tracking; row_max loads on the final push so it is
  // already valid during the DONE cycle alongside the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col     <= '0;
      r_run_max <= '0;
      r_row_max <= '0;
    end else begin
      if (r_state == IDLE && bus.start) r_col <= '0;
      if (w_grant) begin
        r_run_max <= w_new_max;
        r_col     <= w_last ? '0 : r_col + 1'b1;
        if (w_last) r_row_max <= w_new_max;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_grant) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_grant) r_mem[r_wr_ptr] <= bus.vertical_bus;
  end
endmodule

// File: tb/tb_vertical_bus_collector.sv
// Directed bench: an 8-deep and a 4-deep collector driven by simple PE models.
module tb_vertical_bus_collector;
  logic clk, reset;
  int   n_chk, n_pass;

  logic [15:0] pe8 [8];
  logic [15:0] pe4 [8];
  logic [15:0] expq [16];

  vertical_bus_collector_if #(.BITWIDTH(16), .NUM_COLS(8)) bus8 ();
  vertical_bus_collector_if #(.BITWIDTH(16), .NUM_COLS(8)) bus4 ();

  vertical_bus_collector #(.BITWIDTH(16), .NUM_COLS(8), .FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );
  vertical_bus_collector #(.BITWIDTH(16), .NUM_COLS(8), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE models: the granted column drives its value onto the shared bus.
  always_comb begin
    bus8.vertical_bus = '0;
    for (int i = 0; i < 8; i++) if (bus8.send_enable[i]) bus8.vertical_bus = pe8[i];
  end
  always_comb begin
    bus4.vertical_bus = '0;
    for (int i = 0; i < 8; i++) if (bus4.send_enable[i]) bus4.vertical_bus = pe4[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int g, d, idx, dn, pend;
    n_chk = 0; n_pass = 0;
    reset = 1'b1;
    bus8.start = 1'b0; bus8.out_ready = 1'b0;
    bus4.start = 1'b0; bus4.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin pe8[k] = 16'(10*k + 1); pe4[k] = 16'(10*k + 1); end

    // Reset state
    repeat (2) tick();
    chk("rst send_enable", 32'(bus8.send_enable), 32'h0);
    chk("rst out_valid",   32'(bus8.out_valid), 32'h0);
    chk("rst row_max",     32'(bus8.row_max), 32'h0);
    chk("rst row_max_valid", 32'(bus8.row_max_valid), 32'h0);
    chk("rst done",        32'(bus8.done), 32'h0);
    chk("rst busy",        32'(bus8.busy), 32'h0);
    chk("rst4 out_valid",  32'(bus4.out_valid), 32'h0);
    reset = 1'b0;
    tick();

    // Basic row
    bus8.out_ready = 1'b1;
    bus8.start = 1'b1; tick(); bus8.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("basic grant", 32'(bus8.send_enable), 32'(1) << k);
      chk("basic busy", 32'(bus8.busy), 32'h1);
      if (k >= 1) begin
        chk("basic out_valid", 32'(bus8.out_valid), 32'h1);
        chk("basic out_data", 32'(bus8.out_data), 32'(10*(k-1) + 1));
      end
      tick();
    end
    chk("basic done", 32'(bus8.done), 32'h1);
    chk("basic row_max_valid", 32'(bus8.row_max_valid), 32'h1);
    chk("basic row_max", 32'(bus8.row_max), 32'd71);
    chk("basic last word", 32'(bus8.out_data), 32'd71);
    chk("basic done grant", 32'(bus8.send_enable), 32'h0);
    tick();
    chk("basic done pulse end", 32'(bus8.done), 32'h0);
    chk("basic idle busy", 32'(bus8.busy), 32'h0);
    chk("basic drained", 32'(bus8.out_valid), 32'h0);
    chk("basic row_max held", 32'(bus8.row_max), 32'd71);

    // Signed max: mixed negatives
    pe8[0] = 16'hFFFB; pe8[1] = 16'hFFFD; pe8[2] = 16'h8000; pe8[3] = 16'hFFFF;
    pe8[4] = 16'hFFF9; pe8[5] = 16'hFFFE; pe8[6] = 16'hFFF7; pe8[7] = 16'hFFFC;
    bus8.start = 1'b1; tick(); bus8.start = 1'b0;
    repeat (8) tick();
    chk("smax done", 32'(bus8.done), 32'h1);
    chk("smax row_max", 32'(bus8.row_max), 32'h0000FFFF);
    tick();
    // Signed max: all minimum values
    for (int k = 0; k < 8; k++) pe8[k] = 16'h8000;
    bus8.start = 1'b1; tick(); bus8.start = 1'b0;
    repeat (8) tick();
    chk("smin done", 32'(bus8.done), 32'h1);
    chk("smin row_max", 32'(bus8.row_max), 32'h00008000);
    tick();

    // Start while busy: second pulse in cycle 3 is ignored
    for (int k = 0; k < 8; k++) pe8[k] = 16'(10*k + 1);
    g = 0; d = 0;
    bus8.start = 1'b1; tick(); bus8.start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (bus8.send_enable != '0) g++;
      if (bus8.done) d++;
      bus8.start = (c == 3);
      tick();
    end
    bus8.start = 1'b0;
    chk("busy-start grants", 32'(g), 32'd8);
    chk("busy-start dones", 32'(d), 32'd1);
    chk("busy-start idle", 32'(bus8.busy), 32'h0);
    repeat (2) tick();

    // Backpressure: depth 8 never stalls, depth 4 stalls after 4 pushes
    bus8.out_ready = 1'b0; bus4.out_ready = 1'b0;
    bus8.start = 1'b1; bus4.start = 1'b1; tick();
    bus8.start = 1'b0; bus4.start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      chk("bp8 grant", 32'(bus8.send_enable), (c <= 8) ? (32'(1) << (c-1)) : 32'h0);
      chk("bp8 done", 32'(bus8.done), 32'(c == 9));
      chk("bp4 grant", 32'(bus4.send_enable), (c <= 4) ? (32'(1) << (c-1)) : 32'h0);
      chk("bp4 done", 32'(bus4.done), 32'h0);
      tick();
    end
    // Cycle 20: one pop on each
    bus8.out_ready = 1'b1; bus4.out_ready = 1'b1;
    chk("bp4 full stall", 32'(bus4.send_enable), 32'h0);
    chk("bp4 head", 32'(bus4.out_data), 32'd1);
    chk("bp8 head", 32'(bus8.out_data), 32'd1);
    chk("bp8 full valid", 32'(bus8.out_valid), 32'h1);
    tick();
    // Cycle 21: grant resumes after the pop edge
    bus4.out_ready = 1'b0;
    chk("bp4 resume grant", 32'(bus4.send_enable), 32'h10);
    chk("bp8 second", 32'(bus8.out_data), 32'd11);
    tick();
    chk("bp4 restall", 32'(bus4.send_enable), 32'h0);
    for (int k = 2; k <= 7; k++) begin
      chk("bp8 drain", 32'(bus8.out_data), 32'(10*k + 1));
      tick();
    end
    chk("bp8 empty", 32'(bus8.out_valid), 32'h0);
    // Drain depth-4 unit to finish its row
    bus4.out_ready = 1'b1;
    idx = 1; dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus4.out_valid) begin
        chk("bp4 drain", 32'(bus4.out_data), 32'(10*idx + 1));
        idx++;
      end
      if (bus4.done) dn++;
      tick();
    end
    chk("bp4 word count", 32'(idx), 32'd8);
    chk("bp4 dones", 32'(dn), 32'd1);
    chk("bp4 row_max", 32'(bus4.row_max), 32'd71);

    // Reset mid-scan during the col 4 grant
    bus8.out_ready = 1'b0;
    bus8.start = 1'b1; tick(); bus8.start = 1'b0;
    repeat (4) tick();
    chk("pre-reset grant", 32'(bus8.send_enable), 32'h10);
    chk("pre-reset valid", 32'(bus8.out_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("reset grant", 32'(bus8.send_enable), 32'h0);
    chk("reset out_valid", 32'(bus8.out_valid), 32'h0);
    chk("reset row_max", 32'(bus8.row_max), 32'h0);
    chk("reset busy", 32'(bus8.busy), 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Back-to-back rows with toggling out_ready
    for (int k = 0; k < 8; k++) expq[k] = 16'(10*k + 1);
    expq[8]  = 16'd5;   expq[9]  = 16'hFFEC; expq[10] = 16'd300; expq[11] = 16'd7;
    expq[12] = 16'd300; expq[13] = 16'hFFFF; expq[14] = 16'd299; expq[15] = 16'd0;
    bus8.start = 1'b1; tick(); bus8.start = 1'b0;
    chk("restart col0", 32'(bus8.send_enable), 32'h01);
    idx = 0; dn = 0; pend = 0;
    for (int c = 0; c < 80; c++) begin
      bus8.start = pend[0];
      pend = 0;
      bus8.out_ready = (c % 2 == 1);
      if (bus8.out_valid && bus8.out_ready) begin
        if (idx < 16) chk("b2b word", 32'(bus8.out_data), 32'(expq[idx]));
        idx++;
      end
      if (bus8.done) begin
        dn++;
        if (dn == 1) begin
          chk("b2b row_max A", 32'(bus8.row_max), 32'd71);
          for (int k = 0; k < 8; k++) pe8[k] = expq[8+k];
          pend = 1;
        end else begin
          chk("b2b row_max B", 32'(bus8.row_max), 32'd300);
        end
      end
      tick();
    end
    bus8.start = 1'b0;
    chk("b2b word count", 32'(idx), 32'd16);
    chk("b2b dones", 32'(dn), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
